// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg : shared AES constants, FSM state type and GF(2^8) helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int         BYTE_W        = 8;
  localparam logic [7:0] GF_POLY       = 8'h1B;
  localparam logic [7:0] SBOX_AFFINE_C = 8'h63;
  localparam logic [7:0] INV_AFFINE_C  = 8'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and naturally maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox_gf.sv
// ---------------------------------------------------------------------------
// aes_sbox_gf : combinational forward/inverse AES S-box built on one GF inverter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_sbox_gf
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  logic [7:0] inv_aff;
  logic [7:0] gf_in;
  logic [7:0] gf_out;
  logic [7:0] fwd_aff;

  // Inverse mode applies its affine before the inversion, forward after it,
  // so a single inverter serves both directions.
  assign inv_aff = rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ INV_AFFINE_C;
  assign gf_in   = inv ? inv_aff : din;
  assign gf_out  = gf_inv(gf_in);
  assign fwd_aff = gf_out ^ rotl8(gf_out, 1) ^ rotl8(gf_out, 2) ^ rotl8(gf_out, 3)
                 ^ rotl8(gf_out, 4) ^ SBOX_AFFINE_C;
  assign dout    = inv ? gf_out : fwd_aff;

endmodule

`default_nettype wire

// File: rtl/sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// sub_bytes_engine : time-multiplexed SubBytes/InvSubBytes over a valid/ready word
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES    = 16,
  parameter int NUM_SBOX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_inv,
  input  logic [8*LANES-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_inv,
  output logic [8*LANES-1:0]    out_data,
  output logic                  busy
);

  localparam int BEATS = LANES / NUM_SBOX;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (LANES < 1 || NUM_SBOX < 1 || NUM_SBOX > LANES || (LANES % NUM_SBOX) != 0) begin : g_param_check
      $error("sub_bytes_engine: invalid LANES/NUM_SBOX combination");
    end
  endgenerate

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [8*LANES-1:0]   work;
  logic [8*LANES-1:0]   work_next;
  logic                 inv_q;
  logic [7:0]           beat_bytes [BEATS][NUM_SBOX];
  logic [7:0]           sbox_in    [NUM_SBOX];
  logic [7:0]           sbox_out   [NUM_SBOX];

  genvar b, j, i;
  generate
    for (b = 0; b < BEATS; b++) begin : g_beat
      for (j = 0; j < NUM_SBOX; j++) begin : g_slot
        assign beat_bytes[b][j] = work[BYTE_W*(b*NUM_SBOX+j) +: BYTE_W];
      end
    end

    for (j = 0; j < NUM_SBOX; j++) begin : g_sbox
      assign sbox_in[j] = beat_bytes[cnt][j];
      aes_sbox_gf u_sbox (
        .din  (sbox_in[j]),
        .inv  (inv_q),
        .dout (sbox_out[j])
      );
    end

    // Only the bytes of the current beat are replaced; the rest hold.
    for (i = 0; i < LANES; i++) begin : g_wb
      assign work_next[BYTE_W*i +: BYTE_W] = (cnt == CNT_W'(i / NUM_SBOX))
                                           ? sbox_out[i % NUM_SBOX]
                                           : work[BYTE_W*i +: BYTE_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
      inv_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            inv_q <= in_inv;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          work <= work_next;
          if (cnt == CNT_W'(BEATS - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              work  <= in_data;
              inv_q <= in_inv;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_data  = work;
  assign out_inv   = inv_q;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);

endmodule

`default_nettype wire

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
- Parametrised, time-multiplexed SubBytes / InvSubBytes engine for the AES datapath.
- Accepts a LANES-byte word, substitutes NUM_SBOX bytes per cycle through shared S-box instances, and returns the full word over a valid/ready handshake.
- Runtime mode selects forward (encrypt) or inverse (decrypt) substitution, so one engine serves both round pipelines.

Parameters:
- LANES, 16, bytes per word (state width = 8*LANES bits); must be at least 1.
- NUM_SBOX, 4, physical S-box instances; must satisfy 1 <= NUM_SBOX <= LANES and LANES % NUM_SBOX == 0.
- BEATS (localparam), LANES/NUM_SBOX, substitution cycles per word.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  engine can accept a word
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled at accept
- in_data  in  8*LANES  byte i = in_data[8*i+7:8*i]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_inv  out  1  mode used for the presented result
- out_data  out  8*LANES  substituted word, same byte ordering
- busy  out  1  high while in BUSY state

Behaviour:
- Reset:
  - Synchronous, checked on clk edge, overrides all other activity.
  - State -> IDLE; beat counter -> 0; out_data -> 0; out_inv -> 0; out_valid -> 0; busy -> 0.
  - Reset mid-BUSY or mid-DONE discards the word; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, capture in_data into the work register, latch in_inv, clear the counter, and go to BUSY.
  - BUSY: in_ready = 0 and busy = 1.
    - Each cycle, bytes k*NUM_SBOX .. k*NUM_SBOX+NUM_SBOX-1 (k = counter) pass through the S-boxes and are written back in place.
    - The counter increments; after the beat with k = BEATS-1, go to DONE.
    - in_valid is ignored.
  - DONE: out_valid = 1; out_data is the work register, held stable until the handshake; out_inv is the latched mode. in_ready = out_ready.
    - out_ready = 0: stay in DONE; out_data and out_inv are unchanged.
    - out_ready = 1 and in_valid = 0: go to IDLE.
    - out_ready = 1 and in_valid = 1: result consumed and new word accepted in the same cycle; go directly to BUSY.
- Latency: word accepted at edge T; out_valid is high from cycle T+BEATS+1.
  - Throughput is one word per BEATS+1 cycles with back-to-back handshakes.
- Degenerate configuration: NUM_SBOX = LANES gives BEATS = 1, i.e. a single BUSY cycle; no special path.
- Counter width: clog2(BEATS), minimum 1 bit. No wrap occurs because BUSY exits at BEATS-1.
- Mode is per-word. Changing in_inv while BUSY has no effect.
- S-box function (per byte, combinational):
  - Forward: GF(2^8) inverse (0 maps to 0) modulo x^8+x^4+x^3+x+1, then affine transform with constant 0x63.
  - Inverse: inverse affine transform with constant 0x05, then GF(2^8) inverse.
  - Must match the FIPS-197 tables for all 256 values in both modes.
- out_data is registered; no combinational path from in_data to any output. out_valid and in_ready are derived from state only (in_ready also from out_ready in DONE).

Decomposition:
- Package aes_pkg:
  - BYTE_W = 8.
  - GF_POLY = 8'h1B.
  - SBOX_AFFINE_C = 8'h63.
  - INV_AFFINE_C = 8'h05.
  - FSM state enum {IDLE, BUSY, DONE}.
- Sub-module aes_sbox_gf: combinational, ports din[7:0], inv, dout[7:0]; GF inversion plus selectable affine transforms.
  - Instantiated NUM_SBOX times in a generate loop; lane selection is a mux on the counter.

Test Plan:
1. LANES=16, NUM_SBOX=4, in_inv=0, in_data bytes 0..15 = 00,01,19,53,ff,00,... -> out_valid at T+5; out bytes 63,7c,d4,ed,16,63,...; out_inv=0.
2. in_inv=1, bytes 63,7c,d4,ed,16 -> out bytes 00,01,19,53,ff; out_inv=1.
3. Hold out_ready=0 for 10 cycles in DONE, toggling in_data -> out_data stable, in_ready=0, busy=0; out_ready=1 -> IDLE next cycle.
4. Back-to-back: in_valid held high with new word at DONE while out_ready=1 -> second word accepted that cycle, its result valid 5 cycles later; no cycle with both words lost or duplicated.
5. Assert rst during BUSY beat 2 -> next cycle out_valid=0, in_ready=1, out_data=0; following word processes correctly.
6. Exhaustive sweep for LANES=4, NUM_SBOX=4 and LANES=4, NUM_SBOX=1:
   - All 256 byte values in both modes vs a FIPS-197 model.
   - Latency must be T+2 and T+5 respectively.
